// File: rtl/chroni_pkg.sv
// Shared chroni definitions: bus widths and the VRAM arbiter's state and owner
// encodings.
package chroni_pkg;

    localparam int ADDR_W = 13;
    localparam int PAGE_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

endpackage

// File: rtl/chroni_mem_arbiter.sv
// VRAM port arbiter between video fetch (priority) and CPU, with a starvation
// guard for the CPU and a bus timeout that aborts hung memory cycles.
module chroni_mem_arbiter
    import chroni_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [PAGE_W-1:0] vid_page,
    input  logic              vid_req,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [PAGE_W-1:0] cpu_page,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_req,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PAGE_W-1:0] mem_page,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              timeout_err,
    input  logic              clr_err
);

    localparam logic [2:0] MAX_WAIT = 3'(CPU_MAX_WAIT);
    // The abort fires on the edge that ends the TIMEOUT-th BUSY cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [2:0]        starve_cnt, starve_nxt;
    logic [7:0]        tmo_cnt, tmo_nxt;
    logic              vid_ack_nxt, cpu_ack_nxt, mem_req_nxt, mem_we_nxt, err_nxt;
    logic [DATA_W-1:0] vid_rdata_nxt, cpu_rdata_nxt, mem_wdata_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [PAGE_W-1:0] mem_page_nxt;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= OWN_VID;
            starve_cnt  <= '0;
            tmo_cnt     <= '0;
            vid_ack     <= 1'b0;
            vid_rdata   <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            mem_addr    <= '0;
            mem_page    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            mem_req     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            starve_cnt  <= starve_nxt;
            tmo_cnt     <= tmo_nxt;
            vid_ack     <= vid_ack_nxt;
            vid_rdata   <= vid_rdata_nxt;
            cpu_ack     <= cpu_ack_nxt;
            cpu_rdata   <= cpu_rdata_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_page    <= mem_page_nxt;
            mem_we      <= mem_we_nxt;
            mem_wdata   <= mem_wdata_nxt;
            mem_req     <= mem_req_nxt;
            timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        starve_nxt    = starve_cnt;
        tmo_nxt       = tmo_cnt;
        vid_ack_nxt   = 1'b0;
        cpu_ack_nxt   = 1'b0;
        vid_rdata_nxt = vid_rdata;
        cpu_rdata_nxt = cpu_rdata;
        mem_addr_nxt  = mem_addr;
        mem_page_nxt  = mem_page;
        mem_we_nxt    = mem_we;
        mem_wdata_nxt = mem_wdata;
        mem_req_nxt   = mem_req;
        err_nxt       = clr_err ? 1'b0 : timeout_err;

        case (state)
            IDLE: begin
                if (!cpu_req) starve_nxt = '0;
                if (cpu_req && (!vid_req || starve_cnt == MAX_WAIT)) begin
                    owner_nxt     = OWN_CPU;
                    mem_addr_nxt  = cpu_addr;
                    mem_page_nxt  = cpu_page;
                    mem_we_nxt    = cpu_we;
                    mem_wdata_nxt = cpu_wdata;
                    starve_nxt    = '0;
                    mem_req_nxt   = 1'b1;
                    tmo_nxt       = '0;
                    state_nxt     = BUSY;
                end else if (vid_req) begin
                    owner_nxt     = OWN_VID;
                    mem_addr_nxt  = vid_addr;
                    mem_page_nxt  = vid_page;
                    mem_we_nxt    = 1'b0;
                    mem_wdata_nxt = '0;
                    if (cpu_req && starve_cnt != 3'd7) starve_nxt = starve_cnt + 3'd1;
                    mem_req_nxt   = 1'b1;
                    tmo_nxt       = '0;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                    if (owner == OWN_CPU) begin
                        cpu_ack_nxt = 1'b1;
                        if (!mem_we) cpu_rdata_nxt = mem_rdata;
                    end else begin
                        vid_ack_nxt   = 1'b1;
                        vid_rdata_nxt = mem_rdata;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    // Hung memory: release the port and hand the owner a poison byte.
                    mem_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                    err_nxt     = 1'b1;
                    if (owner == OWN_CPU) begin
                        cpu_ack_nxt   = 1'b1;
                        cpu_rdata_nxt = 8'hFF;
                    end else begin
                        vid_ack_nxt   = 1'b1;
                        vid_rdata_nxt = 8'hFF;
                    end
                end else begin
                    tmo_nxt = tmo_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_chroni_mem_arbiter.sv
// Directed scenarios plus a randomized two-requester run scored against a
// transaction-level model of the arbiter and a behavioural VRAM.
module tb_chroni_mem_arbiter;
    import chroni_pkg::*;

    localparam int NV = 30;
    localparam int NC = 20;
    localparam logic [12:0] CPU_A = 13'h111;
    localparam logic [12:0] VID_A = 13'h222;

    logic        vga_clk = 1'b0, reset_n = 1'b0;
    logic [12:0] vid_addr = '0, cpu_addr = '0;
    logic [7:0]  vid_page = '0, cpu_page = '0, cpu_wdata = '0, mem_rdata = '0;
    logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, mem_ack = 1'b0, clr_err = 1'b0;
    logic        vid_ack, cpu_ack, mem_we, mem_req, timeout_err;
    logic [7:0]  vid_rdata, cpu_rdata, mem_page, mem_wdata;
    logic [12:0] mem_addr;
    logic [49:0] all_outs;

    int checks = 0, failures = 0;

    chroni_mem_arbiter #(.CPU_MAX_WAIT(4), .TIMEOUT(255)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .vid_addr(vid_addr), .vid_page(vid_page), .vid_req(vid_req),
        .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_addr(cpu_addr), .cpu_page(cpu_page), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_page(mem_page), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err), .clr_err(clr_err)
    );

    assign all_outs = {vid_ack, vid_rdata, cpu_ack, cpu_rdata, mem_addr, mem_page,
                       mem_we, mem_wdata, mem_req, timeout_err};

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        vid_req = 1'b0; cpu_req = 1'b0; mem_ack = 1'b0; clr_err = 1'b0;
        cpu_we = 1'b0; cpu_wdata = '0; vid_addr = '0; cpu_addr = '0;
        vid_page = '0; cpu_page = '0; mem_rdata = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Behavioural VRAM: unwritten locations read back a fixed function of address.
    logic [7:0] mem_m [int];
    function automatic logic [7:0] rd(input int key);
        if (mem_m.exists(key)) return mem_m[key];
        return 8'(key * 7 + 3);
    endfunction

    logic [12:0] v_addr [NV];
    logic [7:0]  v_page [NV];
    logic [12:0] c_addr [NC];
    logic [7:0]  c_page [NC];
    logic        c_we   [NC];
    logic [7:0]  c_wd   [NC];

    int          vi, ci, streak, delay, g_owner, exp_own, cnt, gi, key;
    bit          pending, exp_v, exp_c, got_v, got_c, pv, pc, both_seen;
    logic [7:0]  exp_rd, last_crd;

    initial begin
        // Reset state
        tick();
        chk("reset_outs", all_outs, '0);
        reset_n = 1'b1;
        tick();
        chk("idle_outs", all_outs, '0);

        // Video alone: req cycle 0, mem_req cycle 1, mem_ack cycle 3, vid_ack cycle 4
        vid_addr = 13'd1025; vid_page = 8'd3; vid_req = 1'b1;
        tick();
        chk("va_mem_req", mem_req, 1);
        chk("va_mem_fields", {mem_addr, mem_page, mem_we, mem_wdata}, {13'd1025, 8'd3, 1'b0, 8'h00});
        tick();
        chk("va_no_early_ack", {vid_ack, cpu_ack, mem_req}, 3'b001);
        tick();
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        tick();
        mem_ack = 1'b0; vid_req = 1'b0;
        chk("va_ack", {vid_ack, cpu_ack, mem_req}, 3'b100);
        chk("va_rdata", vid_rdata, 8'hC3);
        tick();
        chk("va_ack_one_cycle", {vid_ack, vid_rdata}, {1'b0, 8'hC3});

        // Stray ack while idle changes nothing
        mem_ack = 1'b1; mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        chk("stray_idle", {vid_ack, cpu_ack, mem_req, vid_rdata, mem_addr}, {3'b000, 8'hC3, 13'd1025});
        tick();
        chk("stray_stays_idle", mem_req, 0);

        // Chained video: new address on the ack edge, req held
        reset_dut();
        vid_addr = 13'd1025; vid_page = 8'd1; vid_req = 1'b1;
        tick();
        chk("ch_first", {mem_req, mem_addr}, {1'b1, 13'd1025});
        mem_ack = 1'b1; mem_rdata = 8'h11;
        tick();
        mem_ack = 1'b0;
        chk("ch_ack1", {vid_ack, vid_rdata, mem_req}, {1'b1, 8'h11, 1'b0});
        vid_addr = 13'h0543;
        tick();
        chk("ch_second", {mem_req, mem_addr, vid_ack}, {1'b1, 13'h0543, 1'b0});
        mem_ack = 1'b1; mem_rdata = 8'h22;
        tick();
        mem_ack = 1'b0;
        chk("ch_ack2", {vid_ack, vid_rdata, mem_req}, {1'b1, 8'h22, 1'b0});
        vid_req = 1'b0;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            cnt += int'(vid_ack) + int'(mem_req);
        end
        chk("ch_no_dup", cnt, 0);

        // Contention with zero-wait memory: V V V V C repeating
        reset_dut();
        vid_addr = VID_A; vid_req = 1'b1;
        cpu_addr = CPU_A; cpu_we = 1'b1; cpu_wdata = 8'h5A; cpu_req = 1'b1;
        gi = 0; both_seen = 1'b0;
        for (int n = 0; n < 200 && gi < 10; n++) begin
            tick();
            if (vid_ack && cpu_ack) both_seen = 1'b1;
            if (mem_req) begin
                chk($sformatf("ct_owner%0d", gi), mem_addr == CPU_A, (gi % 5) == 4);
                chk($sformatf("ct_wdata%0d", gi), {mem_we, mem_wdata},
                    (mem_addr == CPU_A) ? {1'b1, 8'h5A} : 9'h0);
                gi++;
                mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
            end
        end
        mem_ack = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
        chk("ct_grants", gi, 10);
        chk("ct_ack_exclusive", both_seen, 0);

        // Timeout on a CPU read
        reset_dut();
        cpu_addr = 13'd9; cpu_page = 8'd2; cpu_we = 1'b0; cpu_req = 1'b1;
        tick();
        cnt = 0;
        for (int n = 0; n < 400 && mem_req; n++) begin
            cnt++;
            tick();
        end
        chk("to_busy_len", cnt, 255);
        chk("to_cpu_ack", {cpu_ack, vid_ack, cpu_rdata, timeout_err}, {2'b10, 8'hFF, 1'b1});
        cpu_req = 1'b0;
        tick();
        chk("to_sticky", {cpu_ack, timeout_err}, 2'b01);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_cleared", timeout_err, 0);

        // Video timeout with clr_err held: set wins
        vid_addr = 13'd7; vid_req = 1'b1; clr_err = 1'b1;
        tick();
        cnt = 0;
        for (int n = 0; n < 400 && mem_req; n++) begin
            cnt++;
            tick();
        end
        chk("to2_busy_len", cnt, 255);
        chk("to2_vid_ack", {vid_ack, cpu_ack, vid_rdata, timeout_err}, {2'b10, 8'hFF, 1'b1});
        vid_req = 1'b0; clr_err = 1'b0;
        tick();
        chk("to2_set_wins", timeout_err, 1);

        // Reset mid-transaction
        reset_dut();
        cpu_addr = 13'd5; cpu_we = 1'b1; cpu_wdata = 8'h77; cpu_req = 1'b1;
        tick();
        chk("rm_busy", mem_req, 1);
        tick(); tick();
        #3 reset_n = 1'b0;
        #1;
        chk("rm_async_drop", mem_req, 0);
        cpu_req = 1'b0;
        tick();
        reset_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 8'h55;
        tick();
        mem_ack = 1'b0;
        chk("rm_late_ack", all_outs, '0);
        tick();
        chk("rm_idle", all_outs, '0);

        // Randomized two-requester run
        reset_dut();
        for (int i = 0; i < NV; i++) begin
            v_addr[i] = 13'($urandom_range(0, 15));
            v_page[i] = 8'($urandom_range(0, 1));
        end
        for (int i = 0; i < NC; i++) begin
            c_addr[i] = 13'($urandom_range(0, 15));
            c_page[i] = 8'($urandom_range(0, 1));
            c_we[i]   = 1'($urandom_range(0, 1));
            c_wd[i]   = 8'($urandom);
        end
        vi = 0; ci = 0; streak = 0; delay = 0; g_owner = 0;
        pending = 0; exp_v = 0; exp_c = 0; pv = 0; pc = 0;
        exp_rd = '0; last_crd = '0;
        for (int cyc = 0; cyc < 4000 && !(vi == NV && ci == NC); cyc++) begin
            tick();
            got_v = exp_v; got_c = exp_c;
            exp_v = 0; exp_c = 0;
            chk("rnd_vid_ack", vid_ack, got_v);
            chk("rnd_cpu_ack", cpu_ack, got_c);
            if (got_v) chk("rnd_vid_rdata", vid_rdata, exp_rd);
            if (got_c) begin
                if (!c_we[ci]) last_crd = exp_rd;
                chk("rnd_cpu_rdata", cpu_rdata, last_crd);
            end

            if (mem_req && !pending) begin
                exp_own = (pv && pc) ? ((streak == 4) ? 1 : 0) : (pc ? 1 : (pv ? 0 : 2));
                if (exp_own == 0) begin
                    chk("rnd_grant_vid", {mem_addr, mem_page, mem_we, mem_wdata},
                        {v_addr[vi], v_page[vi], 1'b0, 8'h00});
                    if (pc) streak++;
                end else if (exp_own == 1) begin
                    chk("rnd_grant_cpu", {mem_addr, mem_page, mem_we, mem_wdata},
                        {c_addr[ci], c_page[ci], c_we[ci], c_we[ci] ? c_wd[ci] : cpu_wdata});
                    streak = 0;
                end else begin
                    chk("rnd_spurious_grant", mem_req, 0);
                end
                g_owner = exp_own;
                pending = 1;
                delay = $urandom_range(0, 3);
            end

            mem_ack = 1'b0;
            if (pending) begin
                if (delay == 0) begin
                    pending = 0;
                    mem_ack = 1'b1;
                    if (g_owner == 1) begin
                        key = int'(c_page[ci]) * 8192 + int'(c_addr[ci]);
                        exp_c = 1;
                        if (c_we[ci]) begin
                            mem_m[key] = c_wd[ci];
                            mem_rdata = 8'($urandom);
                        end else begin
                            exp_rd = rd(key);
                            mem_rdata = exp_rd;
                        end
                    end else begin
                        key = int'(v_page[vi]) * 8192 + int'(v_addr[vi]);
                        exp_v = 1;
                        exp_rd = rd(key);
                        mem_rdata = exp_rd;
                    end
                end else begin
                    delay--;
                end
            end

            if (got_v) begin
                vi++;
                vid_req = 1'b0;
            end
            if (got_c) begin
                ci++;
                cpu_req = 1'b0;
            end
            if (!vid_req && vi < NV && (got_v ? $urandom_range(0, 1) == 1 : $urandom_range(0, 2) == 0)) begin
                vid_addr = v_addr[vi]; vid_page = v_page[vi]; vid_req = 1'b1;
            end
            if (!cpu_req && ci < NC && (got_c ? $urandom_range(0, 1) == 1 : $urandom_range(0, 2) == 0)) begin
                cpu_addr = c_addr[ci]; cpu_page = c_page[ci]; cpu_we = c_we[ci];
                cpu_wdata = c_wd[ci]; cpu_req = 1'b1;
            end
            pv = vid_req; pc = cpu_req;
        end
        chk("rnd_vid_done", vi, NV);
        chk("rnd_cpu_done", ci, NC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
